// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//   Register scoreboard for the in-order pipeline. It records the destination
//   of every instruction leaving decode for DEPTH post-decode stages
//   (stage 0 = EX ... stage DEPTH-1 = WB). From that state it derives the
//   decode stall and the per-operand forwarding selects. Each instruction
//   carries the first stage at which its result can be forwarded (issue_lat),
//   so ALU ops (0) and loads (1) go through the same lookup at any depth.
//
// Parameters
//   REG_AW        register address width (2^REG_AW tracked regs, R0 included)
//   DEPTH         tracked post-decode stages, 2..8
//   SEL_W         forwarding select width, 2^SEL_W >= DEPTH+1
//   FLUSH_STAGES  youngest entries killed by flush, 0..DEPTH
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   issue_valid/wen/dest/lat instruction presented by decode this cycle
//   src1/src2, srcN_used     operand addresses and read enables
//   hold                     freeze every entry in place
//   flush                    taken branch: drop the youngest FLUSH_STAGES
//   stall                    decode must not advance
//   fwd_sel1/fwd_sel2        0 = register file, k+1 = result bus of stage k
//   busy                     at least one valid entry in flight
//   stall_count              (PIPE_SCOREBOARD_STATS_EN only) saturating count
//                            of advancing cycles spent stalled
//
// Build option
//   PIPE_SCOREBOARD_STATS_EN  adds the stall_count port and its counter.
// ---------------------------------------------------------------------------

// Per-operand lookup: finds the youngest in-flight writer of src_i and tells
// whether its result is already forwardable.
module pipe_scoreboard_lookup #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 3
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             wen_i,
  input  logic [DEPTH-1:0][REG_AW-1:0] dest_i,
  input  logic [DEPTH-1:0][SEL_W-1:0]  lat_i,
  input  logic [REG_AW-1:0]            src_i,
  input  logic                         used_i,
  output logic                         hazard_o,
  output logic [SEL_W-1:0]             sel_o
);
  logic             hit;
  logic [SEL_W-1:0] hit_k;
  logic [SEL_W-1:0] hit_lat;

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_k   = '0;
    hit_lat = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used_i && valid_i[k] && wen_i[k] && (dest_i[k] == src_i)) begin
        hit     = 1'b1;
        hit_k   = SEL_W'(k);
        hit_lat = lat_i[k];
      end
    end
  end

  // Youngest writer has not yet reached its forwardable stage.
  assign hazard_o = hit && (hit_k < hit_lat);
  assign sel_o    = (hit && !hazard_o) ? SEL_W'(hit_k + SEL_W'(1)) : '0;
endmodule

module pipe_scoreboard #(
  parameter int REG_AW       = 4,
  parameter int DEPTH        = 3,
  parameter int SEL_W        = 3,
  parameter int FLUSH_STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic [SEL_W-1:0]  issue_lat,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2,
`ifdef PIPE_SCOREBOARD_STATS_EN
  output logic [15:0]       stall_count,
`endif
  output logic              busy
);
  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [REG_AW-1:0] dest;
    logic [SEL_W-1:0]  lat;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;

  // Flattened per-field views feeding the lookups.
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0]             ent_wen;
  logic [DEPTH-1:0][REG_AW-1:0] ent_dest;
  logic [DEPTH-1:0][SEL_W-1:0]  ent_lat;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign ent_valid[k] = ent_q[k].valid;
    assign ent_wen[k]   = ent_q[k].wen;
    assign ent_dest[k]  = ent_q[k].dest;
    assign ent_lat[k]   = ent_q[k].lat;
  end

  // Operand lookups, index 0 = src1, index 1 = src2.
  logic [1:0][REG_AW-1:0] op_src;
  logic [1:0]             op_used;
  logic [1:0]             op_haz;
  logic [1:0][SEL_W-1:0]  op_sel;

  assign op_src  = {src2, src1};
  assign op_used = {src2_used, src1_used};

  for (genvar n = 0; n < 2; n++) begin : g_op
    pipe_scoreboard_lookup #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_lookup (
      .valid_i  (ent_valid),
      .wen_i    (ent_wen),
      .dest_i   (ent_dest),
      .lat_i    (ent_lat),
      .src_i    (op_src[n]),
      .used_i   (op_used[n]),
      .hazard_o (op_haz[n]),
      .sel_o    (op_sel[n])
    );
  end

  // A hazard only matters when something is actually trying to issue; a
  // stall also blanks the selects so the held instruction sees no bypass.
  assign stall    = issue_valid & (|op_haz);
  assign fwd_sel1 = stall ? '0 : op_sel[0];
  assign fwd_sel2 = stall ? '0 : op_sel[1];
  assign busy     = |ent_valid;

  // Next state: shift on advance, insert issue or bubble at entry 0, then
  // apply the flush kill to the youngest indices (in place when held).
  always_comb begin
    ent_d = ent_q;
    if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_d[k] = ent_q[k-1];
      end
      ent_d[0].valid = issue_valid & ~stall & ~flush;
      ent_d[0].wen   = issue_wen;
      ent_d[0].dest  = issue_dest;
      ent_d[0].lat   = issue_lat;
    end
    if (flush) begin
      for (int k = 0; k < FLUSH_STAGES; k++) begin
        ent_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

`ifdef PIPE_SCOREBOARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Only advancing stalled cycles are counted; saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_scoreboard
//   Directed bench for pipe_scoreboard at DEPTH=3, FLUSH_STAGES=1. Each step
//   drives the decode inputs, pushes the expected {stall, fwd_sel1, fwd_sel2,
//   busy} onto a scoreboard queue, and pops/compares it mid-cycle before the
//   next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_scoreboard;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 3;
  localparam int SEL_W  = 3;

  logic              clock;
  logic              reset;
  logic              issue_valid, issue_wen;
  logic [REG_AW-1:0] issue_dest;
  logic [SEL_W-1:0]  issue_lat;
  logic [REG_AW-1:0] src1, src2;
  logic              src1_used, src2_used;
  logic              hold, flush;
  logic              stall, busy;
  logic [SEL_W-1:0]  fwd_sel1, fwd_sel2;
`ifdef PIPE_SCOREBOARD_STATS_EN
  logic [15:0]       stall_count;
`endif

  pipe_scoreboard #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .SEL_W(SEL_W), .FLUSH_STAGES(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_wen   (issue_wen),
    .issue_dest  (issue_dest),
    .issue_lat   (issue_lat),
    .src1        (src1),
    .src2        (src2),
    .src1_used   (src1_used),
    .src2_used   (src2_used),
    .hold        (hold),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
`ifdef PIPE_SCOREBOARD_STATS_EN
    .stall_count (stall_count),
`endif
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic             st;
    logic [SEL_W-1:0] f1;
    logic [SEL_W-1:0] f2;
    logic             bz;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic drv(input logic iv, input logic [3:0] d, input logic [2:0] lat,
                     input logic [3:0] s1, input logic u1,
                     input logic [3:0] s2, input logic u2,
                     input logic h, input logic f);
    issue_valid = iv;
    issue_wen   = iv;
    issue_dest  = d;
    issue_lat   = lat;
    src1        = s1;
    src1_used   = u1;
    src2        = s2;
    src2_used   = u2;
    hold        = h;
    flush       = f;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input logic st, input logic [2:0] f1,
                            input logic [2:0] f2, input logic bz);
    exp_t e;
    e.st = st; e.f1 = f1; e.f2 = f2; e.bz = bz;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, compare against the oldest expectation,
  // then move to just after the next rising edge.
  task automatic tick(input string tag);
    exp_t e;
    #2;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".stall"}, 16'(stall),    16'(e.st));
      chk({tag, ".fwd1"},  16'(fwd_sel1), 16'(e.f1));
      chk({tag, ".fwd2"},  16'(fwd_sel2), 16'(e.f2));
      chk({tag, ".busy"},  16'(busy),     16'(e.bz));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(); expect_out(0, 0, 0, 0); tick("reset");

    // ALU chain: EX forward, then WB forward two issues later, then retired.
    drv(1, 3, 0, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("alu_issue");
    drv(1, 9, 0, 3, 1, 0, 0, 0, 0);  expect_out(0, 1, 0, 1); tick("alu_ex_fwd");
    drv(1, 10, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 1); tick("alu_unrel");
    drv(1, 11, 0, 3, 1, 0, 0, 0, 0); expect_out(0, 3, 0, 1); tick("alu_wb_fwd");
    drv(0, 0, 0, 3, 1, 0, 0, 0, 0);  expect_out(0, 0, 0, 1); tick("alu_retired");
    idle(); expect_out(0, 0, 0, 1); tick("alu_drain1");
    idle(); expect_out(0, 0, 0, 1); tick("alu_drain2");
    idle(); expect_out(0, 0, 0, 0); tick("alu_empty");

    // Load-use: one stall, bubble in entry 0, then MEM forward.
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("ld_issue");
    drv(1, 12, 0, 0, 0, 5, 1, 0, 0); expect_out(1, 0, 0, 1); tick("ld_stall");
    drv(1, 12, 0, 0, 0, 5, 1, 0, 0); expect_out(0, 0, 2, 1); tick("ld_fwd");
    drv(0, 0, 0, 5, 1, 12, 1, 0, 0); expect_out(0, 3, 1, 1); tick("ld_bubble");
    idle(); expect_out(0, 0, 0, 1); tick("ld_drain1");
    idle(); expect_out(0, 0, 0, 1); tick("ld_drain2");

    // Youngest match wins.
    drv(1, 4, 0, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("yg_a");
    drv(1, 4, 0, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 1); tick("yg_b");
    drv(1, 13, 0, 4, 1, 0, 0, 0, 0); expect_out(0, 1, 0, 1); tick("yg_young");
    idle(); expect_out(0, 0, 0, 1); tick("yg_drain1");
    idle(); expect_out(0, 0, 0, 1); tick("yg_drain2");
    idle(); expect_out(0, 0, 0, 1); tick("yg_drain3");

    // Flush drops the issuing instruction; older entries survive.
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0);   expect_out(0, 0, 0, 0); tick("fl_a");
    drv(1, 6, 0, 0, 0, 0, 0, 0, 1);   expect_out(0, 0, 0, 1); tick("fl_issue");
    drv(1, 14, 0, 6, 1, 0, 0, 0, 0);  expect_out(0, 0, 0, 1); tick("fl_gone");
    drv(1, 8, 0, 14, 1, 0, 0, 0, 1);  expect_out(0, 1, 0, 1); tick("fl_fwd");
    drv(0, 0, 0, 8, 1, 14, 1, 0, 0);  expect_out(0, 0, 2, 1); tick("fl_drop8");
    idle(); expect_out(0, 0, 0, 1); tick("fl_drain");
    idle(); expect_out(0, 0, 0, 0); tick("fl_empty");

    // Hold freezes entries for three cycles, then the load advances.
    drv(1, 2, 1, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("hd_issue");
    drv(1, 15, 0, 2, 1, 0, 0, 1, 0); expect_out(1, 0, 0, 1); tick("hd_1");
    drv(0, 0, 0, 2, 1, 0, 0, 1, 0);  expect_out(0, 0, 0, 1); tick("hd_2");
    drv(0, 0, 0, 0, 0, 2, 1, 1, 0);  expect_out(0, 0, 0, 1); tick("hd_3");
`ifdef PIPE_SCOREBOARD_STATS_EN
    chk("stat_hold", stall_count, 16'd1);
`endif
    drv(1, 15, 0, 2, 1, 0, 0, 0, 0); expect_out(1, 0, 0, 1); tick("hd_still");
    drv(1, 15, 0, 2, 1, 0, 0, 0, 0); expect_out(0, 2, 0, 1); tick("hd_mem");
    drv(0, 0, 0, 2, 1, 0, 0, 0, 0);  expect_out(0, 3, 0, 1); tick("hd_wb");
    drv(0, 0, 0, 2, 1, 0, 0, 0, 0);  expect_out(0, 0, 0, 1); tick("hd_retired");
    idle(); expect_out(0, 0, 0, 1); tick("hd_drain");

    // Flush while held clears entry 0 in place.
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("hf_issue");
    drv(0, 0, 0, 1, 1, 0, 0, 1, 1);  expect_out(0, 1, 0, 1); tick("hf_pre");
    drv(0, 0, 0, 1, 1, 0, 0, 0, 0);  expect_out(0, 0, 0, 0); tick("hf_cleared");
`ifdef PIPE_SCOREBOARD_STATS_EN
    chk("stat_total", stall_count, 16'd2);
`endif

    // Reset with three valid entries in flight.
    drv(1, 3, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 0); tick("rs_a");
    drv(1, 4, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 1); tick("rs_b");
    drv(1, 5, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 1); tick("rs_c");
    drv(1, 6, 0, 5, 1, 0, 0, 1, 1);
    reset = 1'b1;
    expect_out(0, 1, 0, 1); tick("rs_pre");
    reset = 1'b0;
`ifdef PIPE_SCOREBOARD_STATS_EN
    chk("stat_reset", stall_count, 16'd0);
`endif
    drv(1, 7, 0, 5, 1, 4, 1, 0, 0); expect_out(0, 0, 0, 0); tick("rs_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised register scoreboard for the in-order pipelined CPU, replacing the fixed three-stage hazard and forwarding pair. It tracks the destination register of every instruction issued from decode for `DEPTH` stages. It produces the decode-stage stall and per-operand forwarding selects. Each instruction declares the stage at which its result becomes forwardable, so ALU ops and loads share one mechanism at any pipeline depth.

## Interface
Parameters:
- `REG_AW`, 4: register address width; tracks 2^REG_AW registers. R0 is a real register (implicit result target) and is tracked like any other.
- `DEPTH`, 3: tracked post-decode stages (stage 0 = EX … stage DEPTH-1 = WB); range 2..8.
- `SEL_W`, 3: forwarding select width; must satisfy 2^SEL_W ≥ DEPTH+1.
- `FLUSH_STAGES`, 1: youngest stages invalidated by `flush`; range 0..DEPTH.

Ports:
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: decode presents an instruction this cycle.
- `issue_wen` in 1: the instruction writes a register.
- `issue_dest` in REG_AW: destination register.
- `issue_lat` in SEL_W: first stage index at which the result is forwardable, 0..DEPTH-1. ALU = 0, load = 1.
- `src1`, `src2` in REG_AW: source register addresses.
- `src1_used`, `src2_used` in 1: the operand is actually read.
- `hold` in 1: external freeze (halt, memory wait).
- `flush` in 1: branch/jump resolved taken; kill the youngest instructions.
- `stall` out 1: decode must not advance; the IF/ID buffer holds and the PC pauses.
- `fwd_sel1`, `fwd_sel2` out SEL_W: 0 = register file; k+1 = result bus of stage k.
- `busy` out 1: at least one valid entry is in flight.

## Operation
- State: `DEPTH` entries {valid, wen, dest, lat}. Entry k holds the instruction that issued k+1 advancing cycles ago.
- Match for operand n: entry k is valid, has wen=1, dest==srcN, and srcN_used=1. Only the youngest match (lowest k) counts.
- fwd_selN = k+1 of the youngest match. It is 0 when there is no match, or when the youngest match has k < lat.
- stall = issue_valid & (operand 1 or operand 2 has a youngest match with k < lat). A stall forces both fwd_sel outputs to 0.
- Advance (`hold`=0): entry k+1 ← entry k. Entry 0 ← issued instruction if issue_valid & !stall, otherwise a bubble (valid=0). Entry DEPTH-1 retires; the register file is written that cycle, and the retired entry is no longer matched.
- Hold (`hold`=1): all entries keep their values; stall and fwd are still computed from current state.
- Flush: entries 0..FLUSH_STAGES-1 get valid=0 after the shift. With hold=1, those same indices are cleared in place. The instruction issuing in the same cycle is also dropped.
- `busy` = OR of all entry valid bits.
- Reset: all entries invalid. stall, fwd_sel1, fwd_sel2 and busy read 0 in the cycle after reset is sampled. reset dominates hold and flush.

## Timing
- stall, fwd_sel and busy are combinational from state and the current-cycle inputs, with zero latency.
- Entry updates take effect one clock after sampling.
- Load-use with lat=1: exactly one stall cycle. The following cycle gives fwd_sel = 2 (MEM bus).
- Back-to-back ALU dependence with lat=0: no stall, fwd_sel = 1.
- Reset asserted mid-operation clears every entry on that edge; nothing in flight survives.

## Configuration
- `PIPE_SCOREBOARD_STATS_EN` defined: adds output `stall_count` (16 bits). It increments on every clock where stall=1 and hold=0, saturates at 16'hFFFF, and is cleared by reset.
- Not defined: no port, no counter logic. Behaviour is otherwise identical.

## Test plan
- ALU chain: issue dest=3,lat=0, then src1=3 next cycle → stall=0, fwd_sel1=1. One cycle later an unrelated instruction issues, then another with src1=3 → fwd_sel1=3 (WB, entry 2; DEPTH=3).
- Load-use: issue dest=5,lat=1, then src2=5 → stall=1 for one cycle, then stall=0 with fwd_sel2=2. Entry 0 is a bubble during the stall.
- Youngest priority: dest=4 issued twice in a row, then src1=4 → fwd_sel1=1, not 2.
- Flush, FLUSH_STAGES=1: issue dest=6 with flush=1 in the next cycle, then src1=6 → fwd_sel1=0 and stall=0. The dest=6 entry is gone and busy reflects only the remaining entries.
- Hold: with hold=1 for 3 cycles, fwd_sel stays constant and the entries do not move. After release, the entry retires after DEPTH advancing cycles. With stats enabled, stall_count does not increment during hold.
- Reset mid-stream: assert reset with 3 valid entries → next cycle busy=0, stall=0, fwd_sel1=fwd_sel2=0, and stall_count=0 when stats are enabled.
